// File: rtl/sample_volume_fader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sample_volume_fader_pkg: fader state, gain constants, next-state fn |
// +--------------------------------------------------------------------+
package sample_volume_fader_pkg;

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    STEADY    = 2'd2,
    RAMP_DOWN = 2'd3
  } fade_state_e;

  localparam int GAIN_W        = 8;
  localparam int GAIN_UNITY    = 128;
  localparam int VOL_MAX       = 15;
  localparam int VOL_STEP_GAIN = 8;

  // The state always reflects where cur_gain sits relative to the target.
  function automatic fade_state_e next_state(input logic [GAIN_W-1:0] cur,
                                             input logic [GAIN_W-1:0] tgt);
    fade_state_e ns;
    if (cur < tgt)           ns = RAMP_UP;
    else if (cur > tgt)      ns = RAMP_DOWN;
    else if (tgt == '0)      ns = MUTED;
    else                     ns = STEADY;
    return ns;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sample_volume_fader_gain_ramp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gain_ramp_ctrl: volume register, target gain, frame-paced gain ramp |
// +--------------------------------------------------------------------+
module gain_ramp_ctrl
  import sample_volume_fader_pkg::*;
#(
  parameter int RAMP_DIV = 4,
  parameter int VOL_INIT = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              new_frame,
  input  logic              play,
  input  logic              vol_up,
  input  logic              vol_down,
  output logic [3:0]        volume,
  output logic [GAIN_W-1:0] cur_gain,
  output logic              fading
);

  localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [3:0]        volume_q, volume_d;
  logic [GAIN_W-1:0] cur_gain_q, cur_gain_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  fade_state_e       state_q, state_d;
  logic              fading_q, fading_d;
  logic [GAIN_W-1:0] tgt;
  logic              cnt_last;
  logic              step_en;

  assign tgt = play ? GAIN_W'((GAIN_W'(volume_q) + GAIN_W'(1)) * GAIN_W'(VOL_STEP_GAIN))
                    : '0;
  assign cnt_last = (frame_cnt_q == CNT_W'(RAMP_DIV - 1));
  assign step_en  = new_frame & cnt_last;

  always_comb begin
    volume_d = volume_q;
    if (vol_up && !vol_down && (volume_q != 4'(VOL_MAX)))
      volume_d = volume_q + 4'd1;
    else if (vol_down && !vol_up && (volume_q != 4'd0))
      volume_d = volume_q - 4'd1;

    frame_cnt_d = frame_cnt_q;
    if (new_frame)
      frame_cnt_d = cnt_last ? '0 : frame_cnt_q + CNT_W'(1);

    cur_gain_d = cur_gain_q;
    if (step_en) begin
      if (cur_gain_q < tgt)      cur_gain_d = cur_gain_q + GAIN_W'(1);
      else if (cur_gain_q > tgt) cur_gain_d = cur_gain_q - GAIN_W'(1);
    end

    state_d  = next_state(cur_gain_q, tgt);
    fading_d = (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      volume_q    <= 4'(VOL_INIT);
      cur_gain_q  <= '0;
      frame_cnt_q <= '0;
      state_q     <= MUTED;
      fading_q    <= 1'b0;
    end else begin
      volume_q    <= volume_d;
      cur_gain_q  <= cur_gain_d;
      frame_cnt_q <= frame_cnt_d;
      state_q     <= state_d;
      fading_q    <= fading_d;
    end
  end

  assign volume   = volume_q;
  assign cur_gain = cur_gain_q;
  assign fading   = fading_q;

endmodule
`default_nettype wire

// File: rtl/sample_volume_fader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sample_volume_fader: 3-stage sample x gain pipeline, AC97 side     |
// +--------------------------------------------------------------------+
module sample_volume_fader
  import sample_volume_fader_pkg::*;
#(
  parameter int RAMP_DIV = 4,
  parameter int VOL_INIT = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        new_frame,
  input  logic [15:0] sample_in,
  input  logic        play,
  input  logic        vol_up,
  input  logic        vol_down,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic [3:0]  volume,
  output logic        fading
);

  logic [GAIN_W-1:0] cur_gain;

  gain_ramp_ctrl #(
    .RAMP_DIV (RAMP_DIV),
    .VOL_INIT (VOL_INIT)
  ) u_ctrl (
    .clk       (clk),
    .reset_n   (reset_n),
    .new_frame (new_frame),
    .play      (play),
    .vol_up    (vol_up),
    .vol_down  (vol_down),
    .volume    (volume),
    .cur_gain  (cur_gain),
    .fading    (fading)
  );

  logic        [15:0]       s_q, s_d;
  logic        [GAIN_W-1:0] g_q, g_d;
  logic signed [24:0]       prod_q, prod_d;
  logic                     v1_q, v2_q;
  logic        [15:0]       out_q, out_d;
  logic                     valid_q;
  logic                     unused_prod_bits;

  // Gain is at most unity, so bits [24:23] only ever carry sign copies.
  assign unused_prod_bits = ^{prod_q[24:23], prod_q[6:0]};

  always_comb begin
    s_d    = new_frame ? sample_in : s_q;
    g_d    = new_frame ? cur_gain  : g_q;
    prod_d = v1_q ? (25'($signed(s_q)) * 25'($signed({1'b0, g_q}))) : prod_q;
    out_d  = v2_q ? prod_q[22:7] : out_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q     <= '0;
      g_q     <= '0;
      prod_q  <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      g_q     <= g_d;
      prod_q  <= prod_d;
      v1_q    <= new_frame;
      v2_q    <= v1_q;
      out_q   <= out_d;
      valid_q <= v2_q;
    end
  end

  assign sample_out   = out_q;
  assign sample_valid = valid_q;

endmodule
`default_nettype wire

// File: doc/sample_volume_fader.md
Name: sample_volume_fader

Overview:
- Sits between the music player's sample output and the AC97 interface's playback inputs; the player's 16-bit sample enters, the scaled sample goes to both AC97 channels.
- Applies a user volume (16 steps, stepped by debounced up/down pulses) and a click-free gain ramp when play starts or stops.
- Gain changes only on AC97 frame boundaries (new_frame), so there are no mid-frame discontinuities.

Parameters:
- RAMP_DIV, 4: number of new_frame pulses per 1-LSB gain step (4 frames x 128 steps is about 10.7 ms full-scale at 48 kHz).
- VOL_INIT, 10: volume index loaded at reset (0..15).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- new_frame  in  1  one-clk pulse per AC97 frame, from the AC97 interface
- sample_in  in  16  signed PCM sample from the music player
- play  in  1  level; 1 = playing, 0 = fade to silence
- vol_up  in  1  one-clk pulse from a button unit
- vol_down  in  1  one-clk pulse from a button unit
- sample_out  out  16  signed scaled sample to the AC97 left/right playback inputs
- sample_valid  out  1  one-clk pulse when sample_out updates
- volume  out  4  current volume index, for LEDs
- fading  out  1  high while the gain is ramping

Behaviour:
- Reset values: sample_out=0, sample_valid=0, volume=VOL_INIT, cur_gain=0, frame counter=0, state=MUTED, fading=0.
- Volume control:
  - vol_up increments volume, saturating at 15. vol_down decrements, saturating at 0.
  - vol_up and vol_down high in the same cycle: both ignored.
- Target gain: tgt = play ? (volume+1)*8 : 0. Range 8..128, where 128 = unity.
- Ramp timing:
  - cur_gain is 8-bit unsigned, 0..128.
  - A frame counter counts new_frame pulses modulo RAMP_DIV.
  - On the new_frame where the counter wraps to 0, cur_gain moves 1 toward tgt. Otherwise it holds.
- FSM, evaluated on every clk:
  - MUTED: cur_gain==0 and tgt==0. Go to RAMP_UP when tgt>0.
  - RAMP_UP: cur_gain<tgt. Go to STEADY when equal; go to RAMP_DOWN when tgt<cur_gain.
  - STEADY: cur_gain==tgt. Go to RAMP_UP or RAMP_DOWN when tgt changes.
  - RAMP_DOWN: cur_gain>tgt. Go to MUTED when cur_gain reaches 0 with tgt==0; go to STEADY when cur_gain reaches tgt>0; go to RAMP_UP when tgt rises above cur_gain.
  - fading = (state is RAMP_UP or RAMP_DOWN).
- Play toggled or volume changed mid-ramp: the ramp reverses or retargets from the current cur_gain. No jump.
- Datapath, 3-stage pipeline (edge N = clk edge where new_frame=1):
  - Edge N: s_reg<=sample_in, g_reg<=cur_gain (pre-step value).
  - Edge N+1: prod<=s_reg*g_reg as a signed 25-bit product; gain is zero-extended.
  - Edge N+2: sample_out<=prod>>>7, taking bits [22:7] (arithmetic shift, truncation toward minus infinity); sample_valid=1 for that cycle only.
  - Overflow is impossible because gain is at most 128, so there is no saturation logic.
  - sample_out holds between updates.
- A new_frame arriving while the pipeline is busy is not legal: frames are at least 256 clk apart. No back-pressure.
- reset_n asserted mid-ramp or mid-pipeline: immediate return to the reset values. After release, cur_gain ramps up from 0, never jumping.

Decomposition:
- Package sample_volume_fader_pkg:
  - state enum {MUTED, RAMP_UP, STEADY, RAMP_DOWN}
  - constants GAIN_UNITY=128, GAIN_W=8, VOL_MAX=15, VOL_STEP_GAIN=8
- One natural sub-module, gain_ramp_ctrl: volume register, target computation, frame counter, FSM, cur_gain and fading. The top module holds only the 3-stage multiply pipeline.

Test Plan:
- Reset with play=0 and sample_in=16'h4000 for 10 frames -> sample_out=0 every frame; state MUTED; volume=10; fading=0.
- play=1, RAMP_DIV=4, volume 10 -> fading=1; cur_gain reaches 88 after 352 frames, then STEADY and fading=0. With sample_in=16384, final sample_out=11264, appearing 2 clks after new_frame with sample_valid.
- Five vol_up pulses from volume 10 -> volume saturates at 15; ramp to gain 128; sample_in=-20000 gives sample_out=-20000 (unity).
- At gain 64: sample_in=-1 gives -1; sample_in=1 gives 0; sample_in=16'h8000 gives -16384 (truncation check).
- play drops to 0 at gain 100, then returns to 1 after 40 frames -> gain falls to 90, then rises back toward tgt with no step larger than 1 per RAMP_DIV frames.
- vol_up and vol_down in the same cycle -> volume unchanged. reset_n pulsed mid-ramp at an arbitrary clk phase -> all outputs return to reset values asynchronously.
